// File: rtl/sseg_scan_mux_if.sv
// rtl/sseg_scan_mux_if.sv - digit pattern inputs and display drive outputs of the scan mux
interface sseg_scan_mux_if;
  logic [7:0] sseg0;
  logic [7:0] sseg1;
  logic [7:0] sseg2;
  logic [7:0] sseg3;
  logic [3:0] blank;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_start;

  modport master (
    output sseg0, sseg1, sseg2, sseg3, blank,
    input  an, sseg, frame_start
  );

  modport slave (
    input  sseg0, sseg1, sseg2, sseg3, blank,
    output an, sseg, frame_start
  );
endinterface

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - 4-digit common-anode seven-segment scanner with per-frame latching and dead time
module sseg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input logic            clk,
  input logic            reset,
  sseg_scan_mux_if.slave bus
);

  localparam int             CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [7:0]    sh [4];
  logic [3:0]    sh_blank;
  logic [3:0]    an_q;
  logic [7:0]    sseg_q;
  logic          frame_start_q;

  logic          load;
  logic [3:0]    an_d;
  logic [7:0]    sseg_d;

  // Shadow loads only at the very first cycle of a frame, which is always dead time.
  assign load = (cnt == '0) && (slot == 2'd0);

  always_comb begin
    an_d   = 4'b1111;
    sseg_d = 8'hFF;
    if (cnt >= DEAD && !sh_blank[slot]) begin
      an_d[slot] = 1'b0;
      sseg_d     = sh[slot];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      slot          <= 2'd0;
      for (int i = 0; i < 4; i++) sh[i] <= 8'hFF;
      sh_blank      <= 4'b1111;
      an_q          <= 4'b1111;
      sseg_q        <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      if (cnt == LAST) begin
        cnt  <= '0;
        slot <= slot + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sh[0]    <= bus.sseg0;
        sh[1]    <= bus.sseg1;
        sh[2]    <= bus.sseg2;
        sh[3]    <= bus.sseg3;
        sh_blank <= bus.blank;
      end
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_start_q <= load;
    end
  end

  assign bus.an          = an_q;
  assign bus.sseg        = sseg_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - directed and randomized checks of sseg_scan_mux against a cycle-count model
module tb_sseg_scan_mux;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [4];
  logic [3:0] bl;

  int checks = 0;
  int errors = 0;

  // model: k = cycles since the first cycle with reset low
  int         k = 0;
  logic [7:0] m_sh [4];
  logic [3:0] m_bl;
  logic [3:0] e_an;
  logic [7:0] e_ss;
  logic       e_fs;
  int         gcount = 0;
  int         last_fs = -1;

  sseg_scan_mux_if bus ();

  assign bus.sseg0 = din[0];
  assign bus.sseg1 = din[1];
  assign bus.sseg2 = din[2];
  assign bus.sseg3 = din[3];
  assign bus.blank = bl;

  sseg_scan_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model the current cycle from current inputs, clock it, then compare the now-visible outputs.
  task automatic cycle();
    int p;
    int s;
    if (rst) begin
      e_an = 4'b1111;
      e_ss = 8'hFF;
      e_fs = 1'b0;
      for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
      m_bl = 4'b1111;
      k = 0;
      last_fs = -1;
    end else begin
      p = k % RD;
      s = (k / RD) % 4;
      e_an = 4'b1111;
      e_ss = 8'hFF;
      if (p >= DC && !m_bl[s]) begin
        e_an[s] = 1'b0;
        e_ss = m_sh[s];
      end
      e_fs = (k % FRAME == 0);
      if (k % FRAME == 0) begin
        for (int i = 0; i < 4; i++) m_sh[i] = din[i];
        m_bl = bl;
      end
      k++;
    end
    @(posedge clk);
    #1;
    gcount++;
    chk("an", {4'h0, bus.an}, {4'h0, e_an});
    chk("sseg", bus.sseg, e_ss);
    chk("frame_start", {7'h0, bus.frame_start}, {7'h0, e_fs});
    chk("one_anode", 8'($countones(~bus.an) <= 1), 8'd1);
    if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 8'(gcount - last_fs), 8'(FRAME));
      last_fs = gcount;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // reset with arbitrary inputs
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    bl  = 4'($urandom);
    rst = 1'b1;
    run(3);
    chk("rst_an", {4'h0, bus.an}, 8'h0F);
    chk("rst_sseg", bus.sseg, 8'hFF);
    chk("rst_fs", {7'h0, bus.frame_start}, 8'h00);

    // scan order and frame-consistent update
    din[0] = 8'h81; din[1] = 8'hCF; din[2] = 8'h92; din[3] = 8'h86;
    bl = 4'b0000;
    run(1);
    rst = 1'b0;
    run(1);
    chk("rel_fs", {7'h0, bus.frame_start}, 8'h01);
    run(4);
    chk("slot0_an", {4'h0, bus.an}, 8'h0E);
    chk("slot0_sseg", bus.sseg, 8'h81);
    din[1] = 8'h00;
    run(4);
    chk("dead_an", {4'h0, bus.an}, 8'h0F);
    chk("dead_sseg", bus.sseg, 8'hFF);
    run(3);
    chk("slot1_old", bus.sseg, 8'hCF);
    run(8);
    chk("slot2_an", {4'h0, bus.an}, 8'h0B);
    chk("slot2_sseg", bus.sseg, 8'h92);
    run(8);
    chk("slot3_an", {4'h0, bus.an}, 8'h07);
    chk("slot3_sseg", bus.sseg, 8'h86);
    run(16);
    chk("slot1_new", bus.sseg, 8'h00);

    // blanking, applied and removed only at frame boundaries
    bl = 4'b0100;
    run(32);
    chk("blank_s1_an", {4'h0, bus.an}, 8'h0D);
    run(8);
    chk("blank_s2_an", {4'h0, bus.an}, 8'h0F);
    chk("blank_s2_sseg", bus.sseg, 8'hFF);
    bl = 4'b0000;
    run(2);
    chk("blank_hold", {4'h0, bus.an}, 8'h0F);
    run(30);
    chk("unblank_an", {4'h0, bus.an}, 8'h0B);
    chk("unblank_sseg", bus.sseg, 8'h92);

    // one-cycle reset at cnt 5 of slot 2
    run(33);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_an", {4'h0, bus.an}, 8'h0F);
    chk("midrst_sseg", bus.sseg, 8'hFF);
    cycle();
    chk("midrst_fs", {7'h0, bus.frame_start}, 8'h01);

    // randomized inputs over five frames
    for (int i = 0; i < 5 * FRAME; i++) begin
      for (int d = 0; d < 4; d++) din[d] = 8'($urandom);
      bl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
